// File: rtl/rr_arbiter_16.sv
// Sixteen-way round-robin arbiter with registered one-hot/binary grant and valid/ready handshake.
// Optional: define RR_ARB_CANCEL_EN to let a dropped request withdraw its pending grant.
module rr_arbiter_16 #(
  parameter int N_REQ = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] done
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [N_REQ-1:0]   grant_oh_reg, grant_oh_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [N_REQ-1:0]   done_reg, done_next;

  logic               handshake;
  logic [IDX_W-1:0]   sel_ptr;
  logic [N_REQ-1:0]   sel_mask;
  logic [2*N_REQ-1:0] sel_dbl;
  logic [N_REQ-1:0]   sel_rot;
  logic [IDX_W-1:0]   sel_off;
  logic [IDX_W-1:0]   sel_idx;
  logic [N_REQ-1:0]   sel_oh;
  logic               sel_any;

  assign handshake = (state_reg == GRANT) && out_ready;

  // On a handshake the next winner is searched from just past the served index,
  // and the served bit is masked so it is never re-granted back-to-back.
  assign sel_ptr  = handshake ? grant_idx_reg + 4'd1 : ptr_reg;
  assign sel_mask = req & ~grant_oh_reg;
  assign sel_dbl  = {sel_mask, sel_mask};
  assign sel_any  = |sel_mask;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign sel_rot[gi] = sel_dbl[5'(gi) + {1'b0, sel_ptr}];
    end
  endgenerate

  always_comb begin
    sel_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (sel_rot[i]) sel_off = 4'(i);
    end
  end

  assign sel_idx = sel_ptr + sel_off;
  assign sel_oh  = 16'(1) << sel_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      grant_oh_reg  <= '0;
      grant_idx_reg <= '0;
      done_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      grant_oh_reg  <= grant_oh_next;
      grant_idx_reg <= grant_idx_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    grant_oh_next  = grant_oh_reg;
    grant_idx_next = grant_idx_reg;
    done_next      = '0;
    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          state_next     = GRANT;
          grant_oh_next  = sel_oh;
          grant_idx_next = sel_idx;
        end
      end
      GRANT: begin
        if (handshake) begin
          ptr_next  = grant_idx_reg + 4'd1;
          done_next = grant_oh_reg;
          if (sel_any) begin
            grant_oh_next  = sel_oh;
            grant_idx_next = sel_idx;
          end else begin
            state_next     = IDLE;
            grant_oh_next  = '0;
            grant_idx_next = '0;
          end
        end
`ifdef RR_ARB_CANCEL_EN
        else if (!req[grant_idx_reg]) begin
          state_next     = IDLE;
          grant_oh_next  = '0;
          grant_idx_next = '0;
        end
`endif
      end
      default: begin
        state_next     = IDLE;
        grant_oh_next  = '0;
        grant_idx_next = '0;
      end
    endcase
  end

  always_comb begin
    out_valid = (state_reg == GRANT);
    grant_oh  = grant_oh_reg;
    grant_idx = grant_idx_reg;
    done      = done_reg;
  end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed and randomized bench for rr_arbiter_16, checked every cycle against a
// behavioural model that tracks only "who holds the grant" and the rotating priority.
module tb_rr_arbiter_16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] grant_oh;
  logic [3:0]  grant_idx;
  logic [15:0] done;

  int err_count   = 0;
  int check_count = 0;

  int          m_grant;   // index holding the grant, -1 when none
  int          m_ptr;
  logic [15:0] m_done;

  rr_arbiter_16 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [15:0] mask, input int p);
    for (int k = 0; k < 16; k++) begin
      if (mask[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [15:0] r, input logic rdy, input logic rs);
    logic [15:0] served;
    if (rs) begin
      m_grant = -1;
      m_ptr   = 0;
      m_done  = '0;
      return;
    end
    m_done = '0;
    if (m_grant < 0) begin
      m_grant = pick(r, m_ptr);
    end else if (rdy) begin
      served  = 16'(1) << m_grant;
      m_done  = served;
      m_ptr   = (m_grant + 1) % 16;
      m_grant = pick(r & ~served, m_ptr);
    end
`ifdef RR_ARB_CANCEL_EN
    else if (!r[m_grant]) begin
      m_grant = -1;
    end
`endif
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    logic        exp_valid;
    logic [15:0] exp_oh;
    logic [3:0]  exp_idx;
    @(posedge clk);
    model_step(req, out_ready, rst);
    #1;
    exp_valid = (m_grant >= 0);
    exp_oh    = exp_valid ? 16'(1) << m_grant : 16'h0;
    exp_idx   = exp_valid ? 4'(m_grant) : 4'h0;
    check_value("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    check_value("grant_oh", {16'b0, grant_oh}, {16'b0, exp_oh});
    check_value("grant_idx", {28'b0, grant_idx}, {28'b0, exp_idx});
    check_value("done", {16'b0, done}, {16'b0, m_done});
    if (m_done != 0)
      $display("handshake served idx=%0d next_ptr=%0d t=%0t", $clog2(m_done), m_ptr, $time);
    req = req & ~m_done;
  endtask

  initial begin
    logic [15:0] fresh;
    m_grant = -1;
    m_ptr = 0;
    m_done = '0;
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;

    // Reset and single request
    tick();
    tick();
    check_value("rst_valid", {31'b0, out_valid}, 32'd0);
    check_value("rst_done", {16'b0, done}, 32'd0);
    rst = 1'b0;
    req = 16'h0020;
    out_ready = 1'b1;
    tick();
    check_value("single_oh", {16'b0, grant_oh}, 32'h0020);
    check_value("single_idx", {28'b0, grant_idx}, 32'd5);
    tick();
    check_value("single_done", {16'b0, done}, 32'h0020);

    // Rotation under full contention from ptr = 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_value("rot_idx", {28'b0, grant_idx}, 32'(k));
    end
    tick();
    check_value("rot_last_done", {16'b0, done}, 32'h8000);

    // Wrap-around: serve 14, then 15 and 0
    req = 16'h4000;
    tick();
    tick();
    req = 16'h8001;
    tick();
    check_value("wrap_first", {28'b0, grant_idx}, 32'd15);
    tick();
    check_value("wrap_second", {28'b0, grant_idx}, 32'd0);
    tick();
    out_ready = 1'b0;
    req = 16'h0003;
    tick();
    check_value("wrap_ptr1", {28'b0, grant_idx}, 32'd1);
    out_ready = 1'b1;
    tick();
    tick();

    // Backpressure
    out_ready = 1'b0;
    req = 16'h0008;
    tick();
    req = 16'h0108;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_value("bp_hold", {28'b0, grant_idx}, 32'd3);
    end
    out_ready = 1'b1;
    tick();
    check_value("bp_next", {28'b0, grant_idx}, 32'd8);
    check_value("bp_done", {16'b0, done}, 32'h0008);
    tick();

    // Request withdrawn while stalled
    out_ready = 1'b0;
    req = 16'h0004;
    tick();
    check_value("cancel_grant", {28'b0, grant_idx}, 32'd2);
    req = 16'h0000;
    tick();
`ifdef RR_ARB_CANCEL_EN
    check_value("cancel_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick();
    check_value("cancel_nodone", {16'b0, done}, 32'h0);
`else
    check_value("hold_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check_value("hold_done", {16'b0, done}, 32'h0004);
`endif
    tick();

    // Reset mid-grant
    out_ready = 1'b0;
    req = 16'h0200;
    tick();
    check_value("mid_grant", {28'b0, grant_idx}, 32'd9);
    rst = 1'b1;
    tick();
    check_value("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check_value("mid_rst_oh", {16'b0, grant_oh}, 32'd0);
    check_value("mid_rst_done", {16'b0, done}, 32'd0);
    rst = 1'b0;
    req = 16'h0201;
    out_ready = 1'b1;
    tick();
    check_value("post_rst_idx", {28'b0, grant_idx}, 32'd0);
    tick();
    tick();

    // Randomized traffic: requesters hold until done, new requests arrive at random
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      fresh = 16'($urandom) & 16'($urandom);
      req = req | (fresh & ~m_done);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Sixteen-way round-robin arbiter with a registered one-hot grant, a binary grant index and a valid/ready handshake toward the single shared consumer. It sits directly upstream of the 16:4 encoder/4:16 decoder pair. The one-hot grant feeds the encoder and the binary index feeds decoders and muxes in the consumer stage. Rotating priority prevents starvation among the 16 requesters.

## Interface
- `N_REQ`, 16: number of requesters. Fixed at 16; other values are unsupported.
- `IDX_W`, 4: width of the binary grant index.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 16: per-requester request, level-sensitive.
- `out_valid` out 1: a grant is presented.
- `out_ready` in 1: the consumer accepts the grant. A handshake occurs when `out_valid & out_ready` is high.
- `grant_oh` out 16: registered one-hot grant; all-zero when `out_valid` = 0.
- `grant_idx` out 4: binary index of `grant_oh`; 0 when `out_valid` = 0.
- `done` out 16: one-hot pulse for one cycle, in the cycle after a handshake, marking the served requester.

## Operation
- State: `IDLE`, `GRANT`.
- Registers: `state`, `ptr[3:0]` (highest-priority index), `grant_oh`, `grant_idx`, `done`.
- Selection: the first set bit of `req` scanning `ptr`, `ptr+1`, …, 15, 0, …, `ptr-1`, with modulo-16 wrap.
- `IDLE`:
  - If `req` = 0, stay in `IDLE`.
  - Otherwise register the selected grant, set `out_valid`, and move to `GRANT`.
- `GRANT`:
  - `grant_oh` and `grant_idx` stay stable until a handshake.
  - On a handshake, set `ptr` to `grant_idx + 1` (4-bit wrap, 15→0) and pulse `done` for the served bit on the next cycle.
  - In the same handshake cycle, evaluate `req & ~grant_oh` against the new pointer. If non-zero, register the next grant and stay in `GRANT`. Otherwise go to `IDLE`.
- Requester protocol:
  - A requester holds `req` until its `done` pulse.
  - It drops `req` no later than the cycle `done` is seen.
  - The arbiter never re-grants the just-served bit on the back-to-back path.
- `ptr` changes only on a handshake. Reset value is 0.

## Timing
- Reset values: `state` = `IDLE`, `ptr` = 0, `out_valid` = 0, `grant_oh` = 0, `grant_idx` = 0, `done` = 0.
- Latency: `req` rising in cycle t gives `out_valid` high in t+1 (registered output, no combinational path from `req` to outputs).
- Throughput: one grant per cycle under continuous contention with `out_ready` held at 1.
- `out_ready` high while `out_valid` is low has no effect.
- Reset asserted mid-grant:
  - The next cycle shows all outputs at reset values and `ptr` = 0.
  - No `done` pulse is produced for the abandoned grant.
- `req` changes while in `GRANT` do not alter the current grant. They only affect the next selection.
- All 16 requests asserted: service order starts at `ptr` and proceeds to `ptr+1`, …, wrapping after 15.

## Configuration
- `RR_ARB_CANCEL_EN`
  - Defined: if the granted `req` bit is low in `GRANT` without a handshake, `out_valid`, `grant_oh` and `grant_idx` clear on the next cycle. `state` returns to `IDLE`, `ptr` is unchanged, and no `done` pulse is produced. If a handshake and the drop occur in the same cycle, the handshake wins.
  - Undefined: the grant is held until a handshake regardless of `req`. A withdrawn request is still completed and `done` still pulses.

## Test plan
- **Reset and single request:** hold `rst` for 2 cycles, then `req` = 16'h0020 with `out_ready` = 1.
  - Cycle +1: `out_valid` = 1, `grant_oh` = 16'h0020, `grant_idx` = 5.
  - Next cycle: `done` = 16'h0020, `ptr` = 6.
- **Rotation under contention:** `req` = 16'hFFFF, `out_ready` = 1, each requester drops `req` on its `done`.
  - Grant order is 0, 1, …, 15 on consecutive cycles.
- **Wrap-around:** serve index 14 so that `ptr` = 15, then assert `req` = 16'h8001.
  - Grant 15 first, then 0; `ptr` ends at 1.
- **Backpressure:** grant index 3 with `out_ready` = 0 for 5 cycles while `req` changes to 16'h0108.
  - `grant_idx` stays 3 throughout.
  - After `out_ready` rises, the next grant is index 8.
- **Cancel (with `RR_ARB_CANCEL_EN`):** grant index 2, `out_ready` = 0, then drop `req[2]`.
  - Next cycle: `out_valid` = 0, `ptr` unchanged, no `done` pulse.
  - Without the macro: the grant holds and `done` pulses after `out_ready`.
- **Reset mid-grant:** assert `rst` while `out_valid` = 1 at `grant_idx` = 9.
  - Next cycle: all outputs are 0 and `ptr` = 0.
  - After reset, `req` = 16'h0201 grants index 0 first.
